// File: rtl/razor_pkg.sv
// Shared Razor stage definitions: FSM state encoding and hold-counter sizing.
package razor_pkg;

  typedef enum logic [1:0] {
    RZ_RUN     = 2'd0,
    RZ_RECOVER = 2'd1,
    RZ_HOLD    = 2'd2
  } rz_state_e;

  localparam int RZ_HOLD_W = 4;

  // HOLD runs HOLD_CYC cycles, counting HOLD_CYC-1 down to 0.
  function automatic logic [RZ_HOLD_W-1:0] hold_init(input int hold_cyc);
    return RZ_HOLD_W'(hold_cyc - 1);
  endfunction

endpackage

// File: rtl/razor_reg_n.sv
// W-bit Razor register slice: posedge main flop, negedge shadow, restore mux and mismatch flag.
module razor_reg_n #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic         restore,
  input  logic         shadow_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         mismatch
);

  logic [W-1:0] shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        q <= '0;
    else if (restore) q <= shadow;
    else if (clr)     q <= '0;
    else if (load)    q <= d;
  end

  // Shadow only follows d in the half-cycle after main captured it, so held/restored
  // contents never compare against an unrelated input.
  always_ff @(negedge clk or posedge reset) begin
    if (reset)          shadow <= '0;
    else if (shadow_en) shadow <= d;
  end

  assign mismatch = |(q ^ shadow);

endmodule

// File: rtl/razor_pipe_stage.sv
// Razor pipeline stage: error detection, in-place correction and upstream stall.
// Optional saturating error counter enabled by RAZOR_ERR_CNT_EN.
module razor_pipe_stage
  import razor_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 5,
  parameter int PC_W      = 32,
  parameter int HOLD_CYC  = 1,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [CTRL_W-1:0]    ctrl_in,
  input  logic [PC_W-1:0]      pc_in,
  output logic [DATA_W-1:0]    data_out,
  output logic [CTRL_W-1:0]    ctrl_out,
  output logic [PC_W-1:0]      pc_out,
  output logic                 valid_out,
  output logic                 error_out,
  output logic                 stall_out,
  output logic [ERR_CNT_W-1:0] err_count
);

  rz_state_e            state, state_nxt;
  logic [RZ_HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic                 flush_pend, flush_pend_nxt;
  logic                 cap_en;
  logic                 run, mismatch, flush_eff, do_flush, do_load;
  logic                 mis_data, mis_cv, mis_pc;
  logic [DATA_W-1:0]    data_q;
  logic [CTRL_W:0]      cv_q;
  logic [PC_W-1:0]      pc_q;

  assign run       = (state == RZ_RUN);
  assign mismatch  = run && cv_q[0] && (mis_data || mis_cv || mis_pc);
  assign flush_eff = flush_in || flush_pend;
  assign do_flush  = run && !mismatch && flush_eff;
  assign do_load   = run && !mismatch && !flush_eff && !stall_in;

  razor_reg_n #(.W(DATA_W)) u_data (
    .clk(clk), .reset(reset), .load(do_load), .clr(1'b0), .restore(mismatch),
    .shadow_en(cap_en), .d(data_in), .q(data_q), .mismatch(mis_data)
  );

  // Valid rides in bit 0 of the control slice so a flush clears both together.
  razor_reg_n #(.W(CTRL_W + 1)) u_ctrl (
    .clk(clk), .reset(reset), .load(do_load), .clr(do_flush), .restore(mismatch),
    .shadow_en(cap_en), .d({ctrl_in, valid_in}), .q(cv_q), .mismatch(mis_cv)
  );

  razor_reg_n #(.W(PC_W)) u_pc (
    .clk(clk), .reset(reset), .load(do_load), .clr(1'b0), .restore(mismatch),
    .shadow_en(cap_en), .d(pc_in), .q(pc_q), .mismatch(mis_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RZ_RUN;
      hold_cnt   <= '0;
      flush_pend <= 1'b0;
      cap_en     <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      flush_pend <= flush_pend_nxt;
      cap_en     <= do_load;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    flush_pend_nxt = flush_pend;
    case (state)
      RZ_RUN: begin
        if (mismatch) begin
          state_nxt      = RZ_RECOVER;
          flush_pend_nxt = flush_pend || flush_in;
        end else if (flush_eff) begin
          flush_pend_nxt = 1'b0;
        end
      end
      RZ_RECOVER: begin
        flush_pend_nxt = flush_pend || flush_in;
        if (HOLD_CYC == 0) begin
          state_nxt = RZ_RUN;
        end else begin
          state_nxt    = RZ_HOLD;
          hold_cnt_nxt = hold_init(HOLD_CYC);
        end
      end
      RZ_HOLD: begin
        flush_pend_nxt = flush_pend || flush_in;
        if (hold_cnt == '0) state_nxt = RZ_RUN;
        else                hold_cnt_nxt = hold_cnt - 1'b1;
      end
      default: state_nxt = RZ_RUN;
    endcase
  end

  assign data_out  = data_q;
  assign ctrl_out  = cv_q[0] ? cv_q[CTRL_W:1] : '0;
  assign pc_out    = pc_q;
  assign valid_out = cv_q[0];
  assign error_out = (state == RZ_RECOVER);
  assign stall_out = !run;

`ifdef RAZOR_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        cnt <= '0;
    else if (mismatch && cnt != '1)   cnt <= cnt + 1'b1;
  end

  assign err_count = cnt;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_razor_pipe_stage.sv
// Scoreboard bench for razor_pipe_stage: directed vectors with hand-computed expectations.
module tb_razor_pipe_stage;
  localparam int DW = 32, CW = 5, PW = 32, HC = 2, EW = 2;
`ifdef RAZOR_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in, stall_in, flush_in;
  logic [DW-1:0] data_in;
  logic [CW-1:0] ctrl_in;
  logic [PW-1:0] pc_in;
  logic [DW-1:0] data_out;
  logic [CW-1:0] ctrl_out;
  logic [PW-1:0] pc_out;
  logic          valid_out, error_out, stall_out;
  logic [EW-1:0] err_count;

  int checks = 0;
  int fails  = 0;

  razor_pipe_stage #(
    .DATA_W(DW), .CTRL_W(CW), .PC_W(PW), .HOLD_CYC(HC), .ERR_CNT_W(EW)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
    .data_in(data_in), .ctrl_in(ctrl_in), .pc_in(pc_in), .data_out(data_out),
    .ctrl_out(ctrl_out), .pc_out(pc_out), .valid_out(valid_out), .error_out(error_out),
    .stall_out(stall_out), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid, stall, flush, late;
    logic [DW-1:0] d, ld;
    logic [CW-1:0] c;
    logic [PW-1:0] pc;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic [PW-1:0] epc;
    logic ev, ee, es;
    int   en;
  } vec_t;

  typedef struct {
    int idx;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [PW-1:0] pc;
    logic v, e, s;
    logic [EW-1:0] n;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  // Raw error tally -> counter value the DUT should show.
  function automatic logic [EW-1:0] cnt_model(input int n);
    int sat;
    sat = (1 << EW) - 1;
    if (!CNT_EN) return '0;
    return (n >= sat) ? EW'(sat) : EW'(n);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic void add(input int v, input int st, input int fl, input logic [DW-1:0] d,
                              input int lt, input logic [DW-1:0] ld, input logic [CW-1:0] c,
                              input logic [PW-1:0] pc, input logic [DW-1:0] ed,
                              input logic [CW-1:0] ec, input logic [PW-1:0] epc,
                              input int ev, input int ee, input int es, input int en);
    vec_t t;
    t.valid = (v != 0);  t.stall = (st != 0);  t.flush = (fl != 0);  t.late = (lt != 0);
    t.d = d;  t.ld = ld;  t.c = c;  t.pc = pc;
    t.ed = ed;  t.ec = ec;  t.epc = epc;
    t.ev = (ev != 0);  t.ee = (ee != 0);  t.es = (es != 0);  t.en = en;
    vecs.push_back(t);
  endfunction

  // Inputs are driven 3 time units before the capturing posedge and held past the
  // following negedge; a late value is swapped in between that posedge and negedge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    valid_in = v.valid;  stall_in = v.stall;  flush_in = v.flush;
    data_in  = v.d;      ctrl_in  = v.c;      pc_in    = v.pc;
    e.idx = idx;  e.d = v.ed;  e.c = v.ec;  e.pc = v.epc;
    e.v = v.ev;   e.e = v.ee;  e.s = v.es;  e.n = cnt_model(v.en);
    sb.push_back(e);
    @(posedge clk);
    #2;
    if (v.late) data_in = v.ld;
    #5;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("v%0d data", e.idx),  64'(data_out),  64'(e.d));
        chk($sformatf("v%0d ctrl", e.idx),  64'(ctrl_out),  64'(e.c));
        chk($sformatf("v%0d pc", e.idx),    64'(pc_out),    64'(e.pc));
        chk($sformatf("v%0d valid", e.idx), 64'(valid_out), 64'(e.v));
        chk($sformatf("v%0d error", e.idx), 64'(error_out), 64'(e.e));
        chk($sformatf("v%0d stall", e.idx), 64'(stall_out), 64'(e.s));
        chk($sformatf("v%0d count", e.idx), 64'(err_count), 64'(e.n));
      end
    end
  end

  initial begin : stim
    vec_t p;
    // v st fl data lt late ctrl pc | exp data ctrl pc v err stall raw_errs
    add(1,0,0,'hAA,0,'h0, 5'h03,'h100, 'hAA,5'h03,'h100,1,0,0,0);   // 0 steady
    add(1,0,0,'hAA,0,'h0, 5'h03,'h104, 'hAA,5'h03,'h104,1,0,0,0);   // 1
    add(1,0,0,'h11,1,'h22,5'h01,'h108, 'h11,5'h01,'h108,1,0,0,0);   // 2 late arrival
    add(1,0,0,'h33,0,'h0, 5'h02,'h10C, 'h22,5'h01,'h108,1,1,1,1);   // 3 recover
    add(1,0,0,'h33,0,'h0, 5'h02,'h10C, 'h22,5'h01,'h108,1,0,1,1);   // 4 hold
    add(1,0,0,'h33,0,'h0, 5'h02,'h10C, 'h22,5'h01,'h108,1,0,1,1);   // 5 hold
    add(1,0,0,'h33,0,'h0, 5'h02,'h10C, 'h22,5'h01,'h108,1,0,0,1);   // 6 run
    add(1,0,0,'h33,0,'h0, 5'h02,'h10C, 'h33,5'h02,'h10C,1,0,0,1);   // 7 held instr loads
    add(0,0,0,'h44,1,'h55,5'h04,'h110, 'h44,5'h00,'h110,0,0,0,1);   // 8 late bubble
    add(1,0,0,'h66,0,'h0, 5'h05,'h114, 'h66,5'h05,'h114,1,0,0,1);   // 9 no error
    add(1,0,0,'h77,1,'h78,5'h06,'h118, 'h77,5'h06,'h118,1,0,0,1);   // 10
    add(1,0,0,'h88,0,'h0, 5'h07,'h11C, 'h78,5'h06,'h118,1,1,1,2);   // 11 recover
    add(1,0,1,'h88,0,'h0, 5'h07,'h11C, 'h78,5'h06,'h118,1,0,1,2);   // 12 flush pends
    add(1,0,1,'h88,0,'h0, 5'h07,'h11C, 'h78,5'h06,'h118,1,0,1,2);   // 13 flush pends
    add(1,0,0,'h88,0,'h0, 5'h07,'h11C, 'h78,5'h06,'h118,1,0,0,2);   // 14 back to run
    add(1,0,0,'h88,0,'h0, 5'h07,'h11C, 'h78,5'h00,'h118,0,0,0,2);   // 15 pending flush
    add(1,0,0,'h88,0,'h0, 5'h07,'h11C, 'h88,5'h07,'h11C,1,0,0,2);   // 16
    add(1,0,1,'h99,0,'h0, 5'h08,'h120, 'h88,5'h00,'h11C,0,0,0,2);   // 17 flush in run
    add(1,0,0,'hAB,0,'h0, 5'h09,'h124, 'hAB,5'h09,'h124,1,0,0,2);   // 18
    add(1,1,0,'hCD,1,'hCE,5'h0A,'h128, 'hAB,5'h09,'h124,1,0,0,2);   // 19 stall, late ignored
    add(1,0,0,'hCD,0,'h0, 5'h0A,'h128, 'hCD,5'h0A,'h128,1,0,0,2);   // 20
    add(1,0,0,'h01,1,'h02,5'h01,'h200, 'h01,5'h01,'h200,1,0,0,2);   // 21
    add(1,0,0,'h03,0,'h0, 5'h01,'h204, 'h02,5'h01,'h200,1,1,1,3);   // 22
    add(1,0,0,'h03,0,'h0, 5'h01,'h204, 'h02,5'h01,'h200,1,0,1,3);   // 23
    add(1,0,0,'h03,0,'h0, 5'h01,'h204, 'h02,5'h01,'h200,1,0,1,3);   // 24
    add(1,0,0,'h03,0,'h0, 5'h01,'h204, 'h02,5'h01,'h200,1,0,0,3);   // 25
    add(1,0,0,'h04,1,'h05,5'h01,'h208, 'h04,5'h01,'h208,1,0,0,3);   // 26
    add(1,0,0,'h06,0,'h0, 5'h01,'h20C, 'h05,5'h01,'h208,1,1,1,4);   // 27
    add(1,0,0,'h06,0,'h0, 5'h01,'h20C, 'h05,5'h01,'h208,1,0,1,4);   // 28
    add(1,0,0,'h06,0,'h0, 5'h01,'h20C, 'h05,5'h01,'h208,1,0,1,4);   // 29
    add(1,0,0,'h06,0,'h0, 5'h01,'h20C, 'h05,5'h01,'h208,1,0,0,4);   // 30
    add(1,0,0,'h07,1,'h08,5'h01,'h210, 'h07,5'h01,'h210,1,0,0,4);   // 31
    add(1,0,0,'h09,0,'h0, 5'h01,'h214, 'h08,5'h01,'h210,1,1,1,5);   // 32
    add(1,0,0,'h09,0,'h0, 5'h01,'h214, 'h08,5'h01,'h210,1,0,1,5);   // 33
    add(1,0,0,'h09,0,'h0, 5'h01,'h214, 'h08,5'h01,'h210,1,0,1,5);   // 34
    add(1,0,0,'h09,0,'h0, 5'h01,'h214, 'h08,5'h01,'h210,1,0,0,5);   // 35
    add(1,0,0,'h09,0,'h0, 5'h01,'h214, 'h09,5'h01,'h214,1,0,0,5);   // 36
    add(1,0,0,'h0A,1,'h0B,5'h02,'h300, 'h0A,5'h02,'h300,1,0,0,5);   // 37
    add(1,0,0,'h0C,0,'h0, 5'h02,'h304, 'h0B,5'h02,'h300,1,1,1,6);   // 38 ends in RECOVER

    reset = 1'b1;
    valid_in = 1'b0;  stall_in = 1'b0;  flush_in = 1'b0;
    data_in = '0;     ctrl_in = '0;     pc_in = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #7;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset while the stage sits in RECOVER, checked before the next posedge.
    reset = 1'b1;
    #1;
    chk("rst data",  64'(data_out),  64'(0));
    chk("rst ctrl",  64'(ctrl_out),  64'(0));
    chk("rst pc",    64'(pc_out),    64'(0));
    chk("rst valid", 64'(valid_out), 64'(0));
    chk("rst error", 64'(error_out), 64'(0));
    chk("rst stall", 64'(stall_out), 64'(0));
    chk("rst count", 64'(err_count), 64'(0));
    @(posedge clk);
    #3 reset = 1'b0;
    #4;
    p.valid = 1'b1; p.stall = 1'b0; p.flush = 1'b0; p.late = 1'b0;
    p.d = 'h5A; p.ld = '0; p.c = 5'h03; p.pc = 'h400;
    p.ed = 'h5A; p.ec = 5'h03; p.epc = 'h400;
    p.ev = 1'b1; p.ee = 1'b0; p.es = 1'b0; p.en = 0;
    apply(p, 99);

    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
